apb_sd_spi_ctrl: RTL and testbench

- APB3 slave that runs a hardware SPI master for the SD-card slot, in SPI mode 0.
- Replaces bit-banged GPIO SPI: software loads up to 32 TX bits and a bit count; the block generates SCK/MOSI, samples MISO, and reports completion by status flag and interrupt.
- Sits on the SoC's external APB2 port in the board top level, in the same clock domain as the APB bus.

---
 rtl/apb_sd_spi_ctrl.sv | 150 +++++++++++++++
 tb/tb_apb_sd_spi_ctrl.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/apb_sd_spi_ctrl.sv
// APB3 slave driving a mode-0 SPI master for the SD-card slot (up to 32 bits per transfer).
// Latency: APB zero-wait; n-bit transfer keeps busy high n*2*(DIV+1)+1 clk after the COUNT write.
// Backpressure: none on APB (pready=1); writes to COUNT/TXDATA/DIV are dropped while busy.
module apb_sd_spi_ctrl #(
    parameter logic [7:0] DIV_RESET = 8'd31,
    parameter int         MAX_BITS  = 32
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [7:0]  apb_paddr,
    input  logic        apb_psel,
    input  logic        apb_penable,
    input  logic        apb_pwrite,
    input  logic [31:0] apb_pwdata,
    output logic [31:0] apb_prdata,
    output logic        apb_pready,
    output logic        spi_sck,
    output logic        spi_mosi,
    input  logic        spi_miso,
    output logic        spi_cs_n,
    output logic        irq
);
    localparam int IW = $clog2(MAX_BITS);

    typedef enum logic [1:0] {IDLE, LOW, HIGH, DONE} state_t;

    state_t              state;
    logic                cs;
    logic                irq_en;
    logic [7:0]          div;
    logic [MAX_BITS-1:0] txdata;
    logic [MAX_BITS-1:0] rxdata;
    logic [5:0]          count;
    logic [IW-1:0]       idx;
    logic [7:0]          hc;
    logic                busy;
    logic                done;

    logic                wr;
    logic [5:0]          addr;
    logic [5:0]          req_n;
    logic                unused_addr;

    assign wr          = apb_psel & apb_penable & apb_pwrite;
    assign addr        = apb_paddr[7:2];
    assign unused_addr = &{1'b0, apb_paddr[1:0]};
    // Requested bit count, clipped to the register width.
    assign req_n       = (apb_pwdata[5:0] > 6'(MAX_BITS)) ? 6'(MAX_BITS) : apb_pwdata[5:0];

    assign apb_pready  = 1'b1;
    assign spi_cs_n    = ~cs;
    assign irq         = done & irq_en;

    // Register read mux; unmapped addresses read all ones.
    always_comb begin
        apb_prdata = 32'h0;
        if (apb_psel) begin
            case (addr)
                6'd0:    apb_prdata = {30'h0, irq_en, cs};
                6'd1:    apb_prdata = {24'h0, div};
                6'd2:    apb_prdata = 32'(txdata);
                6'd3:    apb_prdata = 32'(rxdata);
                6'd4:    apb_prdata = {26'h0, count};
                6'd5:    apb_prdata = {30'h0, done, busy};
                default: apb_prdata = 32'hFFFF_FFFF;
            endcase
        end
    end

    // Register writes and the SCK sequencer; DONE sets done after any same-cycle clear.
    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            cs       <= 1'b0;
            irq_en   <= 1'b0;
            div      <= DIV_RESET;
            txdata   <= '0;
            rxdata   <= '0;
            count    <= 6'd0;
            idx      <= '0;
            hc       <= 8'd0;
            busy     <= 1'b0;
            done     <= 1'b0;
            spi_sck  <= 1'b0;
            spi_mosi <= 1'b0;
        end else begin
            if (wr) begin
                case (addr)
                    6'd0: begin
                        cs     <= apb_pwdata[0];
                        irq_en <= apb_pwdata[1];
                    end
                    6'd1: if (!busy) div <= apb_pwdata[7:0];
                    6'd2: if (!busy) txdata <= apb_pwdata[MAX_BITS-1:0];
                    6'd4: begin
                        if (!busy && req_n != 6'd0) begin
                            count    <= req_n;
                            idx      <= IW'(req_n - 6'd1);
                            rxdata   <= '0;
                            done     <= 1'b0;
                            busy     <= 1'b1;
                            state    <= LOW;
                            spi_sck  <= 1'b0;
                            spi_mosi <= txdata[IW'(req_n - 6'd1)];
                            hc       <= div;
                        end
                    end
                    6'd5: if (apb_pwdata[1]) done <= 1'b0;
                    default: ;
                endcase
            end

            case (state)
                LOW: begin
                    if (hc == 8'd0) begin
                        state   <= HIGH;
                        spi_sck <= 1'b1;
                        rxdata  <= {rxdata[MAX_BITS-2:0], spi_miso};
                        hc      <= div;
                    end else begin
                        hc <= hc - 8'd1;
                    end
                end
                HIGH: begin
                    if (hc == 8'd0) begin
                        spi_sck <= 1'b0;
                        count   <= count - 6'd1;
                        if (count == 6'd1) begin
                            state <= DONE;
                        end else begin
                            idx      <= idx - 1'b1;
                            spi_mosi <= txdata[idx - 1'b1];
                            hc       <= div;
                            state    <= LOW;
                        end
                    end else begin
                        hc <= hc - 8'd1;
                    end
                end
                DONE: begin
                    busy     <= 1'b0;
                    done     <= 1'b1;
                    spi_mosi <= 1'b0;
                    state    <= IDLE;
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_apb_sd_spi_ctrl.sv
// Directed bench for apb_sd_spi_ctrl: register access, transfers, busy guard, irq, reset.
// Latency: checks cycle-exact busy length and SCK period against hand-computed values.
// Backpressure: none; APB accesses are two-phase with pready tied high.
module tb_apb_sd_spi_ctrl;
    logic        clk = 1'b0;
    logic        reset;
    logic [7:0]  apb_paddr;
    logic        apb_psel;
    logic        apb_penable;
    logic        apb_pwrite;
    logic [31:0] apb_pwdata;
    logic [31:0] apb_prdata;
    logic        apb_pready;
    logic        spi_sck;
    logic        spi_mosi;
    logic        spi_miso;
    logic        spi_cs_n;
    logic        irq;

    logic        loopback;
    logic        miso_val;
    int          checks = 0;
    int          errors = 0;

    assign spi_miso = loopback ? spi_mosi : miso_val;

    always #5 clk = ~clk;

    apb_sd_spi_ctrl dut (
        .clk         (clk),
        .reset       (reset),
        .apb_paddr   (apb_paddr),
        .apb_psel    (apb_psel),
        .apb_penable (apb_penable),
        .apb_pwrite  (apb_pwrite),
        .apb_pwdata  (apb_pwdata),
        .apb_prdata  (apb_prdata),
        .apb_pready  (apb_pready),
        .spi_sck     (spi_sck),
        .spi_mosi    (spi_mosi),
        .spi_miso    (spi_miso),
        .spi_cs_n    (spi_cs_n),
        .irq         (irq)
    );

    // Write lands on the third rising edge; returns 1ns after it.
    task automatic apb_write(input logic [7:0] a, input logic [31:0] d);
        @(posedge clk); #1;
        apb_psel = 1'b1; apb_pwrite = 1'b1; apb_penable = 1'b0;
        apb_paddr = a; apb_pwdata = d;
        @(posedge clk); #1;
        apb_penable = 1'b1;
        @(posedge clk); #1;
        apb_psel = 1'b0; apb_penable = 1'b0; apb_pwrite = 1'b0;
    endtask

    task automatic apb_read(input logic [7:0] a, output logic [31:0] d);
        @(posedge clk); #1;
        apb_psel = 1'b1; apb_pwrite = 1'b0; apb_penable = 1'b0; apb_paddr = a;
        @(posedge clk); #1;
        apb_penable = 1'b1;
        #1 d = apb_prdata;
        @(posedge clk); #1;
        apb_psel = 1'b0; apb_penable = 1'b0;
    endtask

    // Holds a read of STATUS and samples once per cycle until busy drops (bounded).
    task automatic watch(input int exp_period, output int busy_cyc, output int pulses,
                         output int bad_per, output logic [31:0] mosi_seq,
                         output logic irq_at_fall, output logic mosi_at_fall);
        logic prev_sck;
        int   last_rise;
        apb_psel = 1'b1; apb_penable = 1'b1; apb_pwrite = 1'b0; apb_paddr = 8'h14;
        #1;
        busy_cyc = 0; pulses = 0; bad_per = 0; mosi_seq = 32'h0;
        irq_at_fall = 1'bx; mosi_at_fall = 1'bx;
        prev_sck = 1'b0; last_rise = -1;
        for (int c = 0; c < 4000; c++) begin
            if (apb_prdata[0] !== 1'b1) begin
                irq_at_fall  = irq;
                mosi_at_fall = spi_mosi;
                break;
            end
            busy_cyc++;
            if (spi_sck === 1'b1 && prev_sck === 1'b0) begin
                pulses++;
                mosi_seq = {mosi_seq[30:0], spi_mosi};
                if (last_rise >= 0 && (c - last_rise) != exp_period) bad_per++;
                last_rise = c;
            end
            prev_sck = spi_sck;
            @(posedge clk); #1;
        end
        apb_psel = 1'b0; apb_penable = 1'b0;
    endtask

    task automatic test_reset();
        logic [31:0] r;
        checks++; if (spi_cs_n !== 1'b1) begin errors++; $display("FAIL reset_cs_n: got %b expected 1", spi_cs_n); end
        checks++; if (spi_sck !== 1'b0) begin errors++; $display("FAIL reset_sck: got %b expected 0", spi_sck); end
        checks++; if (irq !== 1'b0) begin errors++; $display("FAIL reset_irq: got %b expected 0", irq); end
        checks++; if (apb_pready !== 1'b1) begin errors++; $display("FAIL pready: got %b expected 1", apb_pready); end
        checks++; if (apb_prdata !== 32'h0) begin errors++; $display("FAIL prdata_idle: got %h expected 0", apb_prdata); end
        apb_read(8'h00, r);
        checks++; if (r !== 32'h0) begin errors++; $display("FAIL reset_ctrl: got %h expected 0", r); end
        apb_read(8'h04, r);
        checks++; if (r !== 32'd31) begin errors++; $display("FAIL reset_div: got %h expected 1f", r); end
        apb_read(8'h08, r);
        checks++; if (r !== 32'h0) begin errors++; $display("FAIL reset_tx: got %h expected 0", r); end
        apb_read(8'h14, r);
        checks++; if (r !== 32'h0) begin errors++; $display("FAIL reset_status: got %h expected 0", r); end
        apb_read(8'h40, r);
        checks++; if (r !== 32'hFFFF_FFFF) begin errors++; $display("FAIL unmapped: got %h expected ffffffff", r); end
    endtask

    task automatic test_single_byte();
        int busy_cyc, pulses, bad_per;
        logic [31:0] seq, r;
        logic irqf, mosif;
        loopback = 1'b1;
        apb_write(8'h04, 32'd0);
        apb_write(8'h08, 32'hA5);
        apb_write(8'h10, 32'd8);
        watch(2, busy_cyc, pulses, bad_per, seq, irqf, mosif);
        checks++; if (busy_cyc != 17) begin errors++; $display("FAIL byte_busy: got %0d expected 17", busy_cyc); end
        checks++; if (pulses != 8) begin errors++; $display("FAIL byte_pulses: got %0d expected 8", pulses); end
        checks++; if (bad_per != 0) begin errors++; $display("FAIL byte_period: %0d periods not 2", bad_per); end
        checks++; if (seq !== 32'hA5) begin errors++; $display("FAIL byte_mosi: got %h expected a5", seq); end
        checks++; if (mosif !== 1'b0) begin errors++; $display("FAIL byte_mosi_end: got %b expected 0", mosif); end
        apb_read(8'h0C, r);
        checks++; if (r !== 32'hA5) begin errors++; $display("FAIL byte_rx: got %h expected a5", r); end
        apb_read(8'h14, r);
        checks++; if (r !== 32'h2) begin errors++; $display("FAIL byte_status: got %h expected 2", r); end
    endtask

    task automatic test_full_word();
        int busy_cyc, pulses, bad_per;
        logic [31:0] seq, r;
        logic irqf, mosif;
        loopback = 1'b0; miso_val = 1'b1;
        apb_write(8'h04, 32'd3);
        apb_write(8'h08, 32'hDEADBEEF);
        apb_write(8'h10, 32'd40);
        watch(8, busy_cyc, pulses, bad_per, seq, irqf, mosif);
        checks++; if (busy_cyc != 257) begin errors++; $display("FAIL word_busy: got %0d expected 257", busy_cyc); end
        checks++; if (pulses != 32) begin errors++; $display("FAIL word_pulses: got %0d expected 32", pulses); end
        checks++; if (bad_per != 0) begin errors++; $display("FAIL word_period: %0d periods not 8", bad_per); end
        checks++; if (seq !== 32'hDEADBEEF) begin errors++; $display("FAIL word_mosi: got %h expected deadbeef", seq); end
        apb_read(8'h0C, r);
        checks++; if (r !== 32'hFFFF_FFFF) begin errors++; $display("FAIL word_rx: got %h expected ffffffff", r); end
    endtask

    task automatic test_busy_protect();
        int busy_cyc, pulses, bad_per;
        logic [31:0] seq, r;
        logic irqf, mosif;
        loopback = 1'b1;
        apb_write(8'h04, 32'd2);
        apb_write(8'h08, 32'hB);
        apb_write(8'h10, 32'd4);
        // Transfer is 4*6+1 = 25 busy cycles; three writes consume 9 of them.
        apb_write(8'h10, 32'd4);
        apb_write(8'h08, 32'h0);
        apb_write(8'h04, 32'd0);
        watch(6, busy_cyc, pulses, bad_per, seq, irqf, mosif);
        checks++; if (busy_cyc != 16) begin errors++; $display("FAIL prot_busy_rest: got %0d expected 16", busy_cyc); end
        apb_read(8'h0C, r);
        checks++; if (r !== 32'hB) begin errors++; $display("FAIL prot_rx: got %h expected b", r); end
        apb_read(8'h08, r);
        checks++; if (r !== 32'hB) begin errors++; $display("FAIL prot_tx: got %h expected b", r); end
        apb_read(8'h04, r);
        checks++; if (r !== 32'd2) begin errors++; $display("FAIL prot_div: got %h expected 2", r); end
        apb_write(8'h10, 32'd0);
        apb_read(8'h14, r);
        checks++; if (r !== 32'h2) begin errors++; $display("FAIL count0_status: got %h expected 2", r); end
        apb_read(8'h10, r);
        checks++; if (r !== 32'h0) begin errors++; $display("FAIL count0_count: got %h expected 0", r); end
    endtask

    task automatic test_irq();
        int busy_cyc, pulses, bad_per;
        logic [31:0] seq, r;
        logic irqf, mosif;
        apb_write(8'h14, 32'h2);
        apb_write(8'h00, 32'h3);
        checks++; if (spi_cs_n !== 1'b0) begin errors++; $display("FAIL cs_assert: got %b expected 0", spi_cs_n); end
        checks++; if (irq !== 1'b0) begin errors++; $display("FAIL irq_idle: got %b expected 0", irq); end
        apb_write(8'h04, 32'd0);
        apb_write(8'h10, 32'd1);
        watch(2, busy_cyc, pulses, bad_per, seq, irqf, mosif);
        checks++; if (busy_cyc != 3) begin errors++; $display("FAIL irq_busy: got %0d expected 3", busy_cyc); end
        checks++; if (irqf !== 1'b1) begin errors++; $display("FAIL irq_rise: got %b expected 1", irqf); end
        apb_write(8'h14, 32'h2);
        checks++; if (irq !== 1'b0) begin errors++; $display("FAIL irq_clear: got %b expected 0", irq); end
        // Second write's edge coincides with the DONE edge of a 1-bit DIV=0 transfer.
        apb_write(8'h10, 32'd1);
        apb_write(8'h14, 32'h2);
        apb_read(8'h14, r);
        checks++; if (r !== 32'h2) begin errors++; $display("FAIL clear_vs_done: got %h expected 2", r); end
        checks++; if (irq !== 1'b1) begin errors++; $display("FAIL irq_after_race: got %b expected 1", irq); end
    endtask

    task automatic test_reset_mid();
        logic [31:0] r;
        miso_val = 1'b1; loopback = 1'b0;
        apb_write(8'h04, 32'd3);
        apb_write(8'h08, 32'hFF);
        apb_write(8'h10, 32'd8);
        repeat (29) @(posedge clk);
        #1;
        checks++; if (spi_sck !== 1'b1) begin errors++; $display("FAIL mid_sck_high: got %b expected 1", spi_sck); end
        reset = 1'b1;
        @(posedge clk); #1;
        checks++; if (spi_sck !== 1'b0) begin errors++; $display("FAIL rst_sck: got %b expected 0", spi_sck); end
        checks++; if (spi_cs_n !== 1'b1) begin errors++; $display("FAIL rst_cs_n: got %b expected 1", spi_cs_n); end
        checks++; if (irq !== 1'b0) begin errors++; $display("FAIL rst_irq: got %b expected 0", irq); end
        reset = 1'b0;
        apb_read(8'h14, r);
        checks++; if (r !== 32'h0) begin errors++; $display("FAIL rst_status: got %h expected 0", r); end
        apb_read(8'h0C, r);
        checks++; if (r !== 32'h0) begin errors++; $display("FAIL rst_rx: got %h expected 0", r); end
        apb_read(8'h04, r);
        checks++; if (r !== 32'd31) begin errors++; $display("FAIL rst_div: got %h expected 1f", r); end
        repeat (20) @(posedge clk);
        #1;
        checks++; if (spi_sck !== 1'b0) begin errors++; $display("FAIL rst_sck_stays: got %b expected 0", spi_sck); end
    endtask

    initial begin
        reset = 1'b1;
        apb_paddr = 8'h0; apb_psel = 1'b0; apb_penable = 1'b0;
        apb_pwrite = 1'b0; apb_pwdata = 32'h0;
        loopback = 1'b0; miso_val = 1'b0;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        test_reset();
        test_single_byte();
        test_full_word();
        test_busy_protect();
        test_irq();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
